// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that wraps a 1W/1R register file as a circular FIFO.
// Flags decode from the registered count; wr_en is the only combinational output.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int AF_LEVEL   = 3,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clear,
   input  logic                  err_clr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AF_L  = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_L  = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   assign full         = (count == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);

   // A pop frees a slot, so a full FIFO can still take a simultaneous push
   assign pop_ok  = rd & ~empty;
   assign push_ok = wr & (~full | pop_ok);
   assign wr_en   = push_ok & ~clear;

   assign w_addr = w_ptr;
   assign r_addr = r_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else if (clear) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else begin
         if (push_ok)
            w_ptr <= w_ptr + 1'b1;
         if (pop_ok)
            r_ptr <= r_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky errors: a new set condition beats err_clr in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr & ~push_ok & ~clear) | (overflow  & ~err_clr);
         underflow <= (rd & ~pop_ok  & ~clear) | (underflow & ~err_clr);
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT and a regfile model.
module tb_fifo_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr, rd, clear, err_clr;
   logic       wr_en;
   logic [1:0] w_addr, r_addr;
   logic       full, empty, almost_full, almost_empty;
   logic [2:0] count;
   logic       overflow, underflow;
   logic [7:0] w_data;
   logic [7:0] r_data;
   logic [7:0] mem [0:3];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef enum int {
      F_WREN, F_WADDR, F_RADDR, F_COUNT, F_FULL, F_EMPTY,
      F_AF, F_AE, F_OVF, F_UNF, F_RDATA
   } fld_e;

   typedef struct {
      int         cyc;
      fld_e       fld;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t q[$];

   fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wr),
      .rd           (rd),
      .clear        (clear),
      .err_clr      (err_clr),
      .wr_en        (wr_en),
      .w_addr       (w_addr),
      .r_addr       (r_addr),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (wr_en) mem[w_addr] <= w_data;
   assign r_data = mem[r_addr];

   function automatic logic [7:0] act(input fld_e f);
      case (f)
         F_WREN:  return {7'd0, wr_en};
         F_WADDR: return {6'd0, w_addr};
         F_RADDR: return {6'd0, r_addr};
         F_COUNT: return {5'd0, count};
         F_FULL:  return {7'd0, full};
         F_EMPTY: return {7'd0, empty};
         F_AF:    return {7'd0, almost_full};
         F_AE:    return {7'd0, almost_empty};
         F_OVF:   return {7'd0, overflow};
         F_UNF:   return {7'd0, underflow};
         default: return r_data;
      endcase
   endfunction

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // Monitor: compare every expectation stamped with the current cycle
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         if (e.cyc < cyc)
            chk({e.name, "_stale"}, 8'd1, 8'd0);
         else
            chk(e.name, act(e.fld), e.val);
      end
   end

   task automatic step(input logic w, input logic r, input logic c,
                       input logic e, input logic [7:0] d);
      @(posedge clk);
      #1;
      wr = w; rd = r; clear = c; err_clr = e; w_data = d;
   endtask

   task automatic ex(input fld_e f, input logic [7:0] v, input string n);
      exp_t e;
      e.cyc = cyc; e.fld = f; e.val = v; e.name = n;
      q.push_back(e);
   endtask

   initial begin
      reset_n = 1'b0;
      wr = 0; rd = 0; clear = 0; err_clr = 0; w_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      step(0, 0, 0, 0, 8'h00);
      ex(F_EMPTY, 1, "rst_empty"); ex(F_FULL, 0, "rst_full");
      ex(F_AE, 1, "rst_ae");       ex(F_AF, 0, "rst_af");
      ex(F_COUNT, 0, "rst_count"); ex(F_WREN, 0, "rst_wren");
      ex(F_OVF, 0, "rst_ovf");     ex(F_UNF, 0, "rst_unf");

      step(1, 0, 0, 0, 8'hA1);
      ex(F_WREN, 1, "p1_wren"); ex(F_WADDR, 0, "p1_waddr"); ex(F_COUNT, 0, "p1_count");
      step(1, 0, 0, 0, 8'hB2);
      ex(F_WREN, 1, "p2_wren"); ex(F_WADDR, 1, "p2_waddr"); ex(F_COUNT, 1, "p2_count");
      ex(F_RDATA, 8'hA1, "p2_rdata"); ex(F_EMPTY, 0, "p2_empty"); ex(F_AE, 1, "p2_ae");
      step(1, 0, 0, 0, 8'hC3);
      ex(F_WREN, 1, "p3_wren"); ex(F_WADDR, 2, "p3_waddr"); ex(F_COUNT, 2, "p3_count");
      ex(F_AE, 0, "p3_ae"); ex(F_AF, 0, "p3_af");
      step(1, 0, 0, 0, 8'hD4);
      ex(F_WREN, 1, "p4_wren"); ex(F_WADDR, 3, "p4_waddr"); ex(F_COUNT, 3, "p4_count");
      ex(F_AF, 1, "p4_af"); ex(F_FULL, 0, "p4_full");

      step(1, 0, 0, 0, 8'hEE);
      ex(F_COUNT, 4, "ovf_count"); ex(F_FULL, 1, "ovf_full"); ex(F_WADDR, 0, "ovf_waddr_wrap");
      ex(F_WREN, 0, "ovf_wren"); ex(F_RDATA, 8'hA1, "ovf_rdata"); ex(F_OVF, 0, "ovf_pre");
      step(0, 0, 0, 1, 8'h00);
      ex(F_OVF, 1, "ovf_set"); ex(F_COUNT, 4, "ovf_count_kept");
      step(0, 0, 0, 0, 8'h00);
      ex(F_OVF, 0, "ovf_cleared");

      step(1, 1, 0, 0, 8'h55);
      ex(F_WREN, 1, "frw_wren"); ex(F_WADDR, 0, "frw_waddr"); ex(F_RADDR, 0, "frw_raddr");
      ex(F_RDATA, 8'hA1, "frw_rdata");
      step(0, 1, 0, 0, 8'h00);
      ex(F_COUNT, 4, "frw_count"); ex(F_FULL, 1, "frw_full"); ex(F_OVF, 0, "frw_ovf");
      ex(F_RDATA, 8'hB2, "d1_rdata"); ex(F_RADDR, 1, "d1_raddr"); ex(F_WADDR, 1, "d1_waddr");
      step(0, 1, 0, 0, 8'h00);
      ex(F_COUNT, 3, "d2_count"); ex(F_RDATA, 8'hC3, "d2_rdata"); ex(F_FULL, 0, "d2_full");
      step(0, 1, 0, 0, 8'h00);
      ex(F_COUNT, 2, "d3_count"); ex(F_RDATA, 8'hD4, "d3_rdata"); ex(F_AF, 0, "d3_af");
      step(0, 1, 0, 0, 8'h00);
      ex(F_COUNT, 1, "d4_count"); ex(F_RDATA, 8'h55, "d4_rdata"); ex(F_RADDR, 0, "d4_raddr_wrap");
      ex(F_AE, 1, "d4_ae");

      step(1, 1, 0, 0, 8'h77);
      ex(F_EMPTY, 1, "erw_empty"); ex(F_COUNT, 0, "erw_count0"); ex(F_RADDR, 1, "erw_raddr");
      ex(F_WREN, 1, "erw_wren"); ex(F_WADDR, 1, "erw_waddr"); ex(F_UNF, 0, "erw_unf_pre");
      step(0, 0, 0, 0, 8'h00);
      ex(F_UNF, 1, "erw_unf"); ex(F_COUNT, 1, "erw_count"); ex(F_RDATA, 8'h77, "erw_rdata");
      ex(F_RADDR, 1, "erw_raddr_kept"); ex(F_WADDR, 2, "erw_waddr_next");

      step(1, 0, 0, 0, 8'h11);
      step(1, 0, 0, 0, 8'h22);
      step(1, 0, 1, 0, 8'h33);
      ex(F_COUNT, 3, "clr_count_pre"); ex(F_WREN, 0, "clr_wren");
      step(0, 1, 0, 1, 8'h00);
      ex(F_COUNT, 0, "clr_count"); ex(F_EMPTY, 1, "clr_empty");
      ex(F_WADDR, 0, "clr_waddr"); ex(F_RADDR, 0, "clr_raddr");
      ex(F_UNF, 1, "clr_unf_kept"); ex(F_OVF, 0, "clr_ovf_kept");
      step(0, 0, 0, 1, 8'h00);
      ex(F_UNF, 1, "unf_set_wins");
      step(0, 0, 0, 0, 8'h00);
      ex(F_UNF, 0, "unf_cleared");

      step(1, 0, 0, 0, 8'hAA);
      step(1, 0, 0, 0, 8'hBB);
      step(0, 0, 0, 0, 8'h00);
      ex(F_COUNT, 2, "ar_count_pre");
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_count", {5'd0, count}, 8'd0);
      chk("ar_empty", {7'd0, empty}, 8'd1);
      chk("ar_waddr", {6'd0, w_addr}, 8'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      step(1, 0, 0, 0, 8'h5A);
      ex(F_COUNT, 0, "ar_resume_count0"); ex(F_WADDR, 0, "ar_resume_waddr");
      ex(F_WREN, 1, "ar_resume_wren");
      step(0, 1, 0, 0, 8'h00);
      ex(F_COUNT, 1, "ar_resume_count1"); ex(F_RDATA, 8'h5A, "ar_resume_rdata");
      ex(F_RADDR, 0, "ar_resume_raddr");
      step(0, 0, 0, 0, 8'h00);
      ex(F_COUNT, 0, "ar_resume_drained"); ex(F_EMPTY, 1, "ar_resume_empty");
      ex(F_RADDR, 1, "ar_resume_raddr1");

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that turns the 2^ADDR_WIDTH-entry register file (1 synchronous write port, 1 asynchronous read port) into a circular FIFO for the UART TX and RX paths.
- Accepts push/pop requests, gates the register-file write enable, and drives the read and write addresses.
- Reports full/empty, occupancy, programmable almost-full/almost-empty levels, and sticky overflow/underflow errors.

Parameters:
- ADDR_WIDTH, 2: address width; FIFO depth = 2^ADDR_WIDTH.
- AF_LEVEL, 3: almost_full asserts when count >= AF_LEVEL. Legal range 1..2^ADDR_WIDTH.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL. Legal range 0..2^ADDR_WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr  in  1  push request; the data is presented to the register file w_data in the same cycle.
- rd  in  1  pop request; the head entry is on the register file r_data this cycle.
- clear  in  1  synchronous flush.
- err_clr  in  1  clears the sticky error flags.
- wr_en  out  1  write enable to the register file.
- w_addr  out  ADDR_WIDTH  write pointer to the register file.
- r_addr  out  ADDR_WIDTH  read pointer to the register file.
- full  out  1  count == 2^ADDR_WIDTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset_n low, asynchronous):
  - w_ptr = r_ptr = 0, count = 0, overflow = underflow = 0.
  - Outputs: empty = 1, full = 0, almost_empty = 1 (AE_LEVEL >= 0), almost_full = 0, wr_en = 0.
  - Reset asserted mid-operation discards all contents immediately.
- State: w_ptr, r_ptr (ADDR_WIDTH bits each), count (ADDR_WIDTH+1 bits), overflow, underflow.
  - w_addr = w_ptr and r_addr = r_ptr, driven directly from the registers.
- Output timing:
  - full, empty, almost_full and almost_empty are decoded from the registered count only. There is no combinational path from wr/rd to them.
  - wr_en is combinational: wr_en = push_ok & ~clear.
- Acceptance rules, evaluated each cycle with clear = 0:
  - pop_ok = rd & ~empty.
  - push_ok = wr & (~full | pop_ok).
  - When full and wr & rd: both are accepted and count is unchanged. The read pops the old head and the write fills the vacated slot.
  - When empty and wr & rd: only the write is accepted, the read is rejected, and underflow sets.
- Pointer and count updates (mod 2^ADDR_WIDTH wrap-around, no special-casing at the top address):
  - push_ok: w_ptr <= w_ptr + 1.
  - pop_ok: r_ptr <= r_ptr + 1.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Read latency:
  - The head data is valid on r_data whenever empty = 0, with zero cycles of latency (asynchronous read).
  - The pop takes effect at the clock edge; the next entry is visible the following cycle.
  - A value pushed at edge N is readable in cycle N+1.
- clear (synchronous, highest priority):
  - w_ptr, r_ptr and count go to 0 at the next edge; wr and rd are ignored that cycle; wr_en = 0.
  - clear does not touch overflow or underflow.
- Error flags:
  - overflow sets on wr & ~push_ok & ~clear.
  - underflow sets on rd & ~pop_ok & ~clear.
  - err_clr zeroes both flags at the edge; a set condition in the same cycle wins, so the flag stays 1.
- Invariants:
  - count == (w_ptr - r_ptr) mod 2^ADDR_WIDTH, except that count == 2^ADDR_WIDTH when w_ptr == r_ptr with full = 1.
  - full and empty are never asserted together.
  - count never exceeds 2^ADDR_WIDTH and never underflows below 0.

Test Plan:
- Reset, then push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles (ADDR_WIDTH = 2) -> wr_en high on all 4 cycles; w_addr goes 0,1,2,3 then wraps to 0; count reaches 4; full = 1, almost_full = 1 after the 3rd push; r_data = 0xA1.
- FIFO full, push 0xEE alone -> wr_en = 0, count stays 4, overflow = 1. Pulse err_clr -> overflow = 0 next cycle.
- FIFO full, wr & rd with 0x55 -> pops 0xA1, writes 0x55 at address 0, count stays 4. Drain 4 pops -> data B2, C3, D4, 55; empty = 1; r_ptr wrapped to 0 then advanced to 1.
- FIFO empty, wr & rd with 0x77 -> wr_en = 1, underflow = 1, count = 1, r_data = 0x77 next cycle.
- Count 3, clear asserted together with wr -> wr_en = 0; next cycle count = 0, empty = 1, pointers 0, error flags unchanged.
- Assert reset_n low between clock edges while count = 2 -> empty = 1 and count = 0 immediately, without waiting for a clock edge; normal push/pop resumes after release.
